// File: rtl/muldiv_arb_pkg.sv
// Types and constants shared by the mul/div arbiter, its interface and the round-robin picker.
package muldiv_arb_pkg;

  localparam int MAX_HARTS   = 8;
  localparam int HART_ID_W   = $clog2(MAX_HARTS);
  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int MULDIV_OP_W = 4;

  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MUL    = 4'd0;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULH   = 4'd1;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULHSU = 4'd2;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULHU  = 4'd3;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIV    = 4'd4;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIVU   = 4'd5;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_REM    = 4'd6;
  localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_REMU   = 4'd7;

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT} arb_state_t;

  typedef struct packed {
    logic [MULDIV_OP_W-1:0] op;
    logic [XLEN-1:0]        a;
    logic [XLEN-1:0]        b;
    logic [REG_ADDR_W-1:0]  rd;
  } muldiv_req_t;

endpackage

// File: rtl/muldiv_arbiter_if.sv
// Hart-side request/response and unit-side issue/completion signals of the mul/div arbiter.
// slave is the arbiter's view; master is the environment (harts plus the unit).
interface muldiv_arbiter_if
  import muldiv_arb_pkg::*;
#(
  parameter int NUM_HARTS = 4,
  parameter int OP_W      = 4
);
  logic [NUM_HARTS-1:0]            req_valid;
  logic [NUM_HARTS-1:0]            req_ready;
  logic [NUM_HARTS*OP_W-1:0]       req_op;
  logic [NUM_HARTS*XLEN-1:0]       req_a;
  logic [NUM_HARTS*XLEN-1:0]       req_b;
  logic [NUM_HARTS*REG_ADDR_W-1:0] req_rd;
  logic [NUM_HARTS-1:0]            flush;
  logic [NUM_HARTS-1:0]            rsp_valid;
  logic [XLEN-1:0]                 rsp_data;
  logic [REG_ADDR_W-1:0]           rsp_rd;

  logic                            muldiv_start;
  logic [OP_W-1:0]                 muldiv_op;
  logic [XLEN-1:0]                 muldiv_a;
  logic [XLEN-1:0]                 muldiv_b;
  logic [REG_ADDR_W-1:0]           muldiv_rd;
  logic [HART_ID_W-1:0]            muldiv_hart_id;
  logic                            muldiv_busy;
  logic                            muldiv_done;
  logic [XLEN-1:0]                 muldiv_result;
  logic [HART_ID_W-1:0]            muldiv_done_hart_id;
  logic [REG_ADDR_W-1:0]           muldiv_done_rd;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
    input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd,
    output req_ready, rsp_valid, rsp_data, rsp_rd,
    output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_rd, muldiv_hart_id
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
    output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd,
    input  req_ready, rsp_valid, rsp_data, rsp_rd,
    input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_rd, muldiv_hart_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, search starts one past the last advanced grant.
// No backpressure of its own; the pointer moves only when the caller asserts advance.
module rr_arbiter
  import muldiv_arb_pkg::*;
#(
  parameter int NUM_HARTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_HARTS-1:0] grant,
  output logic [HART_ID_W-1:0] grant_idx
);

  logic [HART_ID_W-1:0] ptr;
  logic [NUM_HARTS-1:0] upper;
  logic                 found;

  // Prefer requesters at or above the pointer, then wrap to the lowest index.
  always_comb begin
    upper     = '0;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int j = 0; j < NUM_HARTS; j++) begin
      upper[j] = req[j] && (HART_ID_W'(j) >= ptr);
    end
    for (int j = 0; j < NUM_HARTS; j++) begin
      if (!found && upper[j]) begin
        found     = 1'b1;
        grant_idx = HART_ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_HARTS; j++) begin
      if (!found && req[j]) begin
        found     = 1'b1;
        grant_idx = HART_ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_HARTS; j++) begin
      grant[j] = found && (grant_idx == HART_ID_W'(j));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == HART_ID_W'(NUM_HARTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative mul/div unit among NUM_HARTS harts via one-deep per-hart slots and round-robin issue.
// Grant one edge after capture; a slot refuses new work while full or flushed; results of flushed harts are dropped.
module muldiv_arbiter
  import muldiv_arb_pkg::*;
#(
  parameter int NUM_HARTS = 4,
  parameter int OP_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_arbiter_if.slave   bus,
  output logic              err
);

  muldiv_req_t          slot [NUM_HARTS];
  muldiv_req_t          sel;
  logic [NUM_HARTS-1:0] full;
  logic [NUM_HARTS-1:0] pend;
  logic [NUM_HARTS-1:0] take;
  logic [NUM_HARTS-1:0] grant;
  logic [NUM_HARTS-1:0] cur_oh;
  logic [HART_ID_W-1:0] grant_idx;
  logic                 issue;
  logic                 drop;
  logic                 flush_cur;
  arb_state_t           state;

  assign pend          = full & ~bus.flush;
  assign bus.req_ready = ~full & ~bus.flush;
  assign take          = bus.req_valid & bus.req_ready;
  assign issue         = (state == A_IDLE) && (|pend) && !bus.muldiv_busy;
  assign flush_cur     = |(bus.flush & cur_oh);

  rr_arbiter #(.NUM_HARTS(NUM_HARTS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (pend),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (grant[h]) sel = slot[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int h = 0; h < NUM_HARTS; h++) slot[h] <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (take[h]) begin
          full[h] <= 1'b1;
          slot[h] <= '{op: MULDIV_OP_W'(bus.req_op[h*OP_W +: OP_W]),
                       a:  bus.req_a[h*XLEN +: XLEN],
                       b:  bus.req_b[h*XLEN +: XLEN],
                       rd: bus.req_rd[h*REG_ADDR_W +: REG_ADDR_W]};
        end else if (bus.flush[h] || (issue && grant[h])) begin
          full[h] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= A_IDLE;
      cur_oh             <= '0;
      drop               <= 1'b0;
      err                <= 1'b0;
      bus.muldiv_start   <= 1'b0;
      bus.muldiv_op      <= '0;
      bus.muldiv_a       <= '0;
      bus.muldiv_b       <= '0;
      bus.muldiv_rd      <= '0;
      bus.muldiv_hart_id <= '0;
      bus.rsp_valid      <= '0;
      bus.rsp_data       <= '0;
      bus.rsp_rd         <= '0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        A_IDLE: begin
          if (issue) begin
            cur_oh             <= grant;
            bus.muldiv_hart_id <= grant_idx;
            bus.muldiv_op      <= OP_W'(sel.op);
            bus.muldiv_a       <= sel.a;
            bus.muldiv_b       <= sel.b;
            bus.muldiv_rd      <= sel.rd;
            bus.muldiv_start   <= 1'b1;
            state              <= A_ISSUE;
          end
        end
        A_ISSUE: begin
          bus.muldiv_start <= 1'b0;
          if (bus.muldiv_done) err <= 1'b1;
          if (flush_cur) drop <= 1'b1;
          state <= A_WAIT;
        end
        A_WAIT: begin
          if (flush_cur) drop <= 1'b1;
          if (bus.muldiv_done) begin
            bus.rsp_data <= bus.muldiv_result;
            bus.rsp_rd   <= bus.muldiv_done_rd;
            // A flush landing together with done still kills the response.
            if (!(drop || flush_cur)) bus.rsp_valid <= cur_oh;
            if (bus.muldiv_done_hart_id != bus.muldiv_hart_id) err <= 1'b1;
            drop  <= 1'b0;
            state <= A_IDLE;
          end
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural iterative mul/div unit that is not reset with the DUT.
module tb_muldiv_arbiter;
  import muldiv_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  muldiv_arbiter_if #(.NUM_HARTS(4), .OP_W(4)) bus ();

  muldiv_arbiter #(.NUM_HARTS(4), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  // Unit model: special divides finish at the start-sampling edge, MUL 3 edges later, DIV/REM 32 later.
  logic        mbusy = 1'b0;
  logic        mdone = 1'b0;
  logic [31:0] mres  = '0;
  logic [4:0]  mrd   = '0;
  logic [2:0]  mid   = '0;
  int          mcnt  = 0;
  bit          corrupt_id = 1'b0;

  assign bus.muldiv_busy         = mbusy;
  assign bus.muldiv_done         = mdone;
  assign bus.muldiv_result       = mres;
  assign bus.muldiv_done_rd      = mrd;
  assign bus.muldiv_done_hart_id = mid;

  function automatic logic [31:0] mdu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MULDIV_OP_MUL:    return a * b;
      MULDIV_OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      MULDIV_OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      MULDIV_OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MULDIV_OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      MULDIV_OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:          return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int mlat(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (op < MULDIV_OP_DIV) return 3;
    if (b == 0) return 0;
    if ((op == MULDIV_OP_DIV || op == MULDIV_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  always @(posedge clk) begin
    if (bus.muldiv_start) begin
      mres  <= mdu(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
      mrd   <= bus.muldiv_rd;
      mid   <= bus.muldiv_hart_id ^ {2'b00, corrupt_id};
      mbusy <= 1'b1;
      if (mlat(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b) == 0) mdone <= 1'b1;
      else mcnt <= mlat(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end else if (mdone) begin
      mdone <= 1'b0;
      mbusy <= 1'b0;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int h, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    bus.req_valid[h]      = 1'b1;
    bus.req_op[h*4 +: 4]  = op;
    bus.req_a[h*32 +: 32] = a;
    bus.req_b[h*32 +: 32] = b;
    bus.req_rd[h*5 +: 5]  = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int st_c[8], st_id[8], rs_c[8], rs_v[8], rs_d[8];
  int nst, nrs;

  task automatic mon_clear();
    nst = 0;
    nrs = 0;
  endtask

  task automatic tick_mon(int c);
    tick();
    if (bus.muldiv_start && nst < 8) begin
      st_c[nst] = c; st_id[nst] = int'(bus.muldiv_hart_id); nst++;
    end
    if (bus.rsp_valid != 0 && nrs < 8) begin
      rs_c[nrs] = c; rs_v[nrs] = int'(bus.rsp_valid); rs_d[nrs] = int'(bus.rsp_data); nrs++;
    end
  endtask

  typedef struct {
    int          hart;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  int   n;

  initial begin
    vecs[0] = '{1, MULDIV_OP_MUL,   32'd7,           32'd6,           5'd5,  32'd42,          6};
    vecs[1] = '{2, MULDIV_OP_DIVU,  32'd100,         32'd0,           5'd7,  32'hFFFF_FFFF,   3};
    vecs[2] = '{2, MULDIV_OP_DIV,   -32'sd20,        32'd3,           5'd8,  32'hFFFF_FFFA,   35};
    vecs[3] = '{0, MULDIV_OP_MULHU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   5'd1,  32'hFFFF_FFFE,   6};
    vecs[4] = '{3, MULDIV_OP_REM,   -32'sd20,        32'd3,           5'd31, 32'hFFFF_FFFE,   35};
    vecs[5] = '{1, MULDIV_OP_DIV,   32'h8000_0000,   32'hFFFF_FFFF,   5'd2,  32'h8000_0000,   3};
    vecs[6] = '{0, MULDIV_OP_REMU,  32'd100,         32'd0,           5'd3,  32'd100,         3};
    vecs[7] = '{3, MULDIV_OP_MULH,  -32'sd2,         32'd3,           5'd9,  32'hFFFF_FFFF,   6};

    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rd = '0; bus.flush = '0;
    tick();
    do_reset();

    chk("rst_req_ready", {28'b0, bus.req_ready}, 32'hF);
    chk("rst_rsp_valid", {28'b0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_data",  bus.rsp_data, 32'h0);
    chk("rst_err",       {31'b0, err}, 32'h0);
    chk("rst_start",     {31'b0, bus.muldiv_start}, 32'h0);

    // Single requests: latency from capture edge, one-hot routing, data, rd, pulse width.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].hart, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      tick();
      bus.req_valid = '0;
      n = 0;
      while (bus.rsp_valid == 0 && n < 60) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
      chk($sformatf("v%0d_rsp_valid", i), {28'b0, bus.rsp_valid}, 32'd1 << vecs[i].hart);
      chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].exp);
      chk($sformatf("v%0d_rsp_rd", i), {27'b0, bus.rsp_rd}, {27'b0, vecs[i].rd});
      tick();
      chk($sformatf("v%0d_pulse", i), {28'b0, bus.rsp_valid}, 32'h0);
      tick();
    end

    // Contention: 0,2,3 together, then hart 0 refills behind hart 2's op.
    do_reset();
    send(0, MULDIV_OP_MUL, 32'd2, 32'd2, 5'd1);
    send(2, MULDIV_OP_MUL, 32'd3, 32'd3, 5'd2);
    send(3, MULDIV_OP_MUL, 32'd4, 32'd4, 5'd3);
    tick();
    bus.req_valid = '0;
    mon_clear();
    for (int c = 1; c <= 30; c++) begin
      if (c == 9) send(0, MULDIV_OP_MUL, 32'd5, 32'd5, 5'd4);
      tick_mon(c);
      bus.req_valid = '0;
    end
    chk("cont_nstart", nst, 4);
    chk("cont_s0_cyc", st_c[0], 1);  chk("cont_s0_id", st_id[0], 0);
    chk("cont_s1_cyc", st_c[1], 7);  chk("cont_s1_id", st_id[1], 2);
    chk("cont_s2_cyc", st_c[2], 13); chk("cont_s2_id", st_id[2], 3);
    chk("cont_s3_cyc", st_c[3], 19); chk("cont_s3_id", st_id[3], 0);
    chk("cont_last_data", rs_d[3], 32'd25);

    // Flush of the in-flight hart and of a queued, ungranted slot.
    do_reset();
    send(3, MULDIV_OP_REM, 32'd100, 32'd7, 5'd9);
    tick();
    bus.req_valid = '0;
    mon_clear();
    for (int c = 1; c <= 50; c++) begin
      if (c == 3) begin
        send(1, MULDIV_OP_MUL, 32'd3, 32'd4, 5'd11);
        send(2, MULDIV_OP_MUL, 32'd5, 32'd5, 5'd12);
      end
      if (c == 5) begin
        bus.flush = 4'b1000;
        send(3, MULDIV_OP_MUL, 32'd1, 32'd1, 5'd13);
        #1;
        chk("flush_req_ready", {31'b0, bus.req_ready[3]}, 32'h0);
      end
      if (c == 6) bus.flush = 4'b0100;
      tick_mon(c);
      bus.req_valid = '0;
      bus.flush = '0;
    end
    chk("flush_nstart", nst, 2);
    chk("flush_s0_cyc", st_c[0], 1);  chk("flush_s0_id", st_id[0], 3);
    chk("flush_s1_cyc", st_c[1], 36); chk("flush_s1_id", st_id[1], 1);
    chk("flush_nrsp", nrs, 1);
    chk("flush_rsp_cyc", rs_c[0], 41);
    chk("flush_rsp_valid", rs_v[0], 32'b0010);
    chk("flush_rsp_data", rs_d[0], 32'd12);

    // Wrong hart id on done: sticky error, response still goes to the current hart.
    do_reset();
    corrupt_id = 1'b1;
    send(1, MULDIV_OP_MUL, 32'd2, 32'd3, 5'd4);
    tick();
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid == 0 && n < 20) begin
      tick();
      n++;
    end
    corrupt_id = 1'b0;
    chk("err_set", {31'b0, err}, 32'h1);
    chk("err_rsp_valid", {28'b0, bus.rsp_valid}, 32'b0010);
    chk("err_rsp_data", bus.rsp_data, 32'd6);
    repeat (3) tick();
    chk("err_held", {31'b0, err}, 32'h1);

    // Reset mid-DIV: outputs clear, late done ignored, no issue until the unit's busy drops.
    send(0, MULDIV_OP_DIV, 32'd1000, 32'd7, 5'd6);
    tick();
    bus.req_valid = '0;
    repeat (9) tick();
    do_reset();
    chk("mid_rst_err",       {31'b0, err}, 32'h0);
    chk("mid_rst_start",     {31'b0, bus.muldiv_start}, 32'h0);
    chk("mid_rst_hart_id",   {29'b0, bus.muldiv_hart_id}, 32'h0);
    chk("mid_rst_a",         bus.muldiv_a, 32'h0);
    chk("mid_rst_rsp_data",  bus.rsp_data, 32'h0);
    chk("mid_rst_rsp_rd",    {27'b0, bus.rsp_rd}, 32'h0);
    chk("mid_rst_req_ready", {28'b0, bus.req_ready}, 32'hF);
    mon_clear();
    send(2, MULDIV_OP_MUL, 32'd9, 32'd9, 5'd3);
    for (int c = 11; c <= 50; c++) begin
      tick_mon(c);
      bus.req_valid = '0;
    end
    chk("post_rst_nstart", nst, 1);
    chk("post_rst_s0_cyc", st_c[0], 36);
    chk("post_rst_s0_id", st_id[0], 2);
    chk("post_rst_nrsp", nrs, 1);
    chk("post_rst_rsp_cyc", rs_c[0], 41);
    chk("post_rst_rsp_valid", rs_v[0], 32'b0100);
    chk("post_rst_rsp_data", rs_d[0], 32'd81);
    chk("post_rst_err", {31'b0, err}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
